// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state names, opcode and
// function-code values, and the datapath mux select encodings.
package multicycle_control_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_e;

   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   localparam logic [1:0] PC_SRC_INC  = 2'd0;
   localparam logic [1:0] PC_SRC_ALU  = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP = 2'd2;
   localparam logic [1:0] PC_SRC_REG  = 2'd3;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_R2 = 2'd2;

   localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
   localparam logic [1:0] MEM_TO_REG_MDR = 2'd1;
   localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

   localparam logic [1:0] ALU_B_RT   = 2'd0;
   localparam logic [1:0] ALU_B_SIMM = 2'd1;
   localparam logic [1:0] ALU_B_ZIMM = 2'd2;

   // R-type function codes 0-7 are the ALU operations
   function automatic logic isAluFunc(input logic [5:0] fn);
      return fn < 6'd8;
   endfunction

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational instruction classifier: maps opcode/function code onto one-hot
// class flags consumed by the controller state machine.
module opcode_decode
   import multicycle_control_pkg::*;
(
   input  logic [3:0] opcode_i,
   input  logic [5:0] funcode_i,
   output logic       isBranch_o,
   output logic       isAdi_o,
   output logic       isZeroImm_o,
   output logic       isLoad_o,
   output logic       isStore_o,
   output logic       isJmp_o,
   output logic       isJal_o,
   output logic       isJpr_o,
   output logic       isJrl_o,
   output logic       isWwd_o,
   output logic       isHlt_o,
   output logic       isAluR_o,
   output logic       isNop_o
);

   // Anything not recognised falls into isNop_o so the controller can retire it
   always_comb begin
      isBranch_o  = 1'b0;
      isAdi_o     = 1'b0;
      isZeroImm_o = 1'b0;
      isLoad_o    = 1'b0;
      isStore_o   = 1'b0;
      isJmp_o     = 1'b0;
      isJal_o     = 1'b0;
      isJpr_o     = 1'b0;
      isJrl_o     = 1'b0;
      isWwd_o     = 1'b0;
      isHlt_o     = 1'b0;
      isAluR_o    = 1'b0;
      isNop_o     = 1'b0;
      case (opcode_i)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: isBranch_o  = 1'b1;
         OP_ADI:                         isAdi_o     = 1'b1;
         OP_ORI, OP_LHI:                 isZeroImm_o = 1'b1;
         OP_LWD:                         isLoad_o    = 1'b1;
         OP_SWD:                         isStore_o   = 1'b1;
         OP_JMP:                         isJmp_o     = 1'b1;
         OP_JAL:                         isJal_o     = 1'b1;
         OP_RTYPE: begin
            if (isAluFunc(funcode_i)) begin
               isAluR_o = 1'b1;
            end else begin
               case (funcode_i)
                  FN_JPR:  isJpr_o = 1'b1;
                  FN_JRL:  isJrl_o = 1'b1;
                  FN_WWD:  isWwd_o = 1'b1;
                  FN_HLT:  isHlt_o = 1'b1;
                  default: isNop_o = 1'b1;
               endcase
            end
         end
         default: isNop_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor controller: IF/ID/EX/MEM/WB/HALT sequencer producing
// datapath control strobes and a retired-instruction counter.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int WORD_SIZE = 16
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [3:0]           opcode,
   input  logic [5:0]           funcode,
   input  logic                 mem_ready,
   input  logic                 bcond,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 reg_write,
   output logic [1:0]           pc_source,
   output logic [1:0]           reg_dst,
   output logic [1:0]           mem_to_reg,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 wwd_en,
   output logic                 halted,
   output logic [WORD_SIZE-1:0] num_inst
);

   state_e               state_q, state_d;
   logic [WORD_SIZE-1:0] numInst_q;
   logic                 retire;

   logic isBranch, isAdi, isZeroImm, isLoad, isStore, isJmp, isJal;
   logic isJpr, isJrl, isWwd, isHlt, isAluR, isNop;

   // The datapath gates the PC write with bcond; the controller only raises pc_write_cond
   logic unusedBcond;
   assign unusedBcond = bcond;

   opcode_decode uDecode (
      .opcode_i    (opcode),
      .funcode_i   (funcode),
      .isBranch_o  (isBranch),
      .isAdi_o     (isAdi),
      .isZeroImm_o (isZeroImm),
      .isLoad_o    (isLoad),
      .isStore_o   (isStore),
      .isJmp_o     (isJmp),
      .isJal_o     (isJal),
      .isJpr_o     (isJpr),
      .isJrl_o     (isJrl),
      .isWwd_o     (isWwd),
      .isHlt_o     (isHlt),
      .isAluR_o    (isAluR),
      .isNop_o     (isNop)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IF;
         numInst_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            numInst_q <= numInst_q + WORD_SIZE'(1);
         end
      end
   end

   assign num_inst = numInst_q;

   // Outputs are gated by reset_n so they read zero during reset even though the state is IF
   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      pc_source     = PC_SRC_INC;
      reg_dst       = REG_DST_RT;
      mem_to_reg    = MEM_TO_REG_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = ALU_B_RT;
      wwd_en        = 1'b0;
      halted        = 1'b0;
      if (reset_n) begin
         case (state_q)
            S_IF: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  pc_source = PC_SRC_INC;
                  state_d   = S_ID;
               end
            end
            S_ID: begin
               retire  = 1'b1;
               state_d = S_IF;
               if (isJmp || isJal || isJpr || isJrl) begin
                  pc_write  = 1'b1;
                  pc_source = (isJpr || isJrl) ? PC_SRC_REG : PC_SRC_JUMP;
                  if (isJal || isJrl) begin
                     reg_write  = 1'b1;
                     reg_dst    = REG_DST_R2;
                     mem_to_reg = MEM_TO_REG_PC;
                  end
               end else if (isWwd) begin
                  wwd_en = 1'b1;
               end else if (isHlt) begin
                  state_d = S_HALT;
               end else if (!isNop) begin
                  retire  = 1'b0;
                  state_d = S_EX;
               end
            end
            S_EX: begin
               if (isBranch) begin
                  alu_src_a     = 1'b1;
                  alu_src_b     = ALU_B_RT;
                  pc_write_cond = 1'b1;
                  pc_source     = PC_SRC_ALU;
                  retire        = 1'b1;
                  state_d       = S_IF;
               end else if (isLoad || isStore) begin
                  alu_src_a = 1'b1;
                  alu_src_b = ALU_B_SIMM;
                  state_d   = S_MEM;
               end else if (isAdi) begin
                  alu_src_b = ALU_B_SIMM;
                  state_d   = S_WB;
               end else if (isZeroImm) begin
                  alu_src_b = ALU_B_ZIMM;
                  state_d   = S_WB;
               end else begin
                  alu_src_a = isAluR;
                  alu_src_b = ALU_B_RT;
                  state_d   = S_WB;
               end
            end
            S_MEM: begin
               i_or_d    = 1'b1;
               mem_read  = isLoad;
               mem_write = isStore;
               if (mem_ready) begin
                  if (isLoad) begin
                     state_d = S_WB;
                  end else begin
                     retire  = 1'b1;
                     state_d = S_IF;
                  end
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               reg_dst    = isAluR ? REG_DST_RD : REG_DST_RT;
               mem_to_reg = isLoad ? MEM_TO_REG_MDR : MEM_TO_REG_ALU;
               retire     = 1'b1;
               state_d    = S_IF;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: begin
               state_d = S_IF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: a per-instruction cycle table is derived from the
// instruction class and replayed against the controller cycle by cycle.
module tb_multicycle_control;

   // A narrow counter keeps the wrap-around reachable in a short run
   localparam int WS  = 10;
   localparam int MOD = 1 << WS;

   typedef struct packed {
      logic       memRead;
      logic       memWrite;
      logic       iOrD;
      logic       irWrite;
      logic       pcWrite;
      logic       pcWriteCond;
      logic       regWrite;
      logic [1:0] pcSource;
      logic [1:0] regDst;
      logic [1:0] memToReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       wwdEn;
      logic       halted;
   } ctl_t;

   typedef struct {
      logic memReady;
      logic bcond;
      ctl_t ctl;
   } step_t;

   logic          clk;
   logic          reset_n;
   logic [3:0]    opcode;
   logic [5:0]    funcode;
   logic          mem_ready;
   logic          bcond;
   logic          mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
   logic          reg_write, alu_src_a, wwd_en, halted;
   logic [1:0]    pc_source, reg_dst, mem_to_reg, alu_src_b;
   logic [WS-1:0] num_inst;
   ctl_t          obs;

   step_t expQ[$];
   int    checks     = 0;
   int    errors     = 0;
   int    modelCount = 0;
   int    bcForce    = -1;
   string curTag     = "";

   logic [5:0] fnList [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                               6'd25, 6'd26, 6'd28, 6'd27, 6'd30, 6'd63};

   multicycle_control #(.WORD_SIZE(WS)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .opcode        (opcode),
      .funcode       (funcode),
      .mem_ready     (mem_ready),
      .bcond         (bcond),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .reg_write     (reg_write),
      .pc_source     (pc_source),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .wwd_en        (wwd_en),
      .halted        (halted),
      .num_inst      (num_inst)
   );

   assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
                 pc_source, reg_dst, mem_to_reg, alu_src_a, alu_src_b, wwd_en, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic pushStep(input logic memReady, input ctl_t c);
      step_t s;
      s.memReady = memReady;
      s.bcond    = (bcForce < 0) ? rnd() : bcForce[0];
      s.ctl      = c;
      expQ.push_back(s);
   endtask

   // Expected cycle table for one instruction, built from its class
   task automatic buildInstr(input logic [3:0] op, input logic [5:0] fn,
                             input int waitIf, input int waitMem);
      ctl_t c;
      logic isJump, isLink;
      isJump = (op == 4'd9) || (op == 4'd10) || (op == 4'd15 && (fn == 6'd25 || fn == 6'd26));
      isLink = (op == 4'd10) || (op == 4'd15 && fn == 6'd26);
      for (int i = 0; i < waitIf; i++) begin
         c = '0; c.memRead = 1'b1;
         pushStep(1'b0, c);
      end
      c = '0; c.memRead = 1'b1; c.irWrite = 1'b1; c.pcWrite = 1'b1;
      pushStep(1'b1, c);
      c = '0;
      if (isJump) begin
         c.pcWrite  = 1'b1;
         c.pcSource = (op == 4'd15) ? 2'd3 : 2'd2;
         if (isLink) begin
            c.regWrite = 1'b1; c.regDst = 2'd2; c.memToReg = 2'd2;
         end
         pushStep(rnd(), c);
      end else if (op == 4'd15 && fn == 6'd28) begin
         c.wwdEn = 1'b1;
         pushStep(rnd(), c);
      end else if ((op inside {[4'd11:4'd14]}) || (op == 4'd15 && fn >= 6'd8)) begin
         pushStep(rnd(), c);
      end else begin
         pushStep(rnd(), c);
         if (op <= 4'd3) begin
            c.aluSrcA = 1'b1; c.pcWriteCond = 1'b1; c.pcSource = 2'd1;
            pushStep(rnd(), c);
         end else if (op == 4'd7 || op == 4'd8) begin
            c.aluSrcA = 1'b1; c.aluSrcB = 2'd1;
            pushStep(rnd(), c);
            c = '0; c.iOrD = 1'b1; c.memRead = (op == 4'd7); c.memWrite = (op == 4'd8);
            for (int i = 0; i < waitMem; i++) pushStep(1'b0, c);
            pushStep(1'b1, c);
            if (op == 4'd7) begin
               c = '0; c.regWrite = 1'b1; c.memToReg = 2'd1;
               pushStep(rnd(), c);
            end
         end else begin
            if (op == 4'd4) c.aluSrcB = 2'd1;
            else if (op == 4'd5 || op == 4'd6) c.aluSrcB = 2'd2;
            else c.aluSrcA = 1'b1;
            pushStep(rnd(), c);
            c = '0; c.regWrite = 1'b1; c.regDst = (op == 4'd15) ? 2'd1 : 2'd0;
            pushStep(rnd(), c);
         end
      end
   endtask

   task automatic checkOutput(input string tag, input ctl_t expV);
      checks++;
      assert (obs === expV)
         else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expV);
         end
   endtask

   task automatic checkCount(input string tag, input logic [WS-1:0] expV);
      checks++;
      assert (num_inst === expV)
         else begin
            errors++;
            $error("[TB] FAIL %s num_inst: observed %h expected %h", tag, num_inst, expV);
         end
   endtask

   // Replays n table rows: drive inputs, sample at the falling edge, step one clock
   task automatic applyStimulus(input int n);
      step_t s;
      for (int i = 0; i < n; i++) begin
         s = expQ.pop_front();
         mem_ready = s.memReady;
         bcond     = s.bcond;
         @(negedge clk);
         checkOutput($sformatf("%s cycle %0d", curTag, i), s.ctl);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runInstr(input string tag, input logic [3:0] op, input logic [5:0] fn,
                           input int waitIf, input int waitMem);
      curTag  = tag;
      opcode  = op;
      funcode = fn;
      expQ.delete();
      buildInstr(op, fn, waitIf, waitMem);
      applyStimulus(expQ.size());
      modelCount = (modelCount + 1) % MOD;
      checkCount(tag, modelCount[WS-1:0]);
   endtask

   initial begin
      ctl_t       zero;
      ctl_t       haltV;
      logic [3:0] rop;
      logic [5:0] rfn;
      zero        = '0;
      haltV       = '0;
      haltV.halted = 1'b1;
      reset_n   = 1'b0;
      opcode    = 4'd0;
      funcode   = 6'd0;
      mem_ready = 1'b1;
      bcond     = 1'b0;

      #1;
      checkOutput("resetT0", zero);
      checkCount("resetT0", '0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetHeld", zero);
      checkCount("resetHeld", '0);
      reset_n = 1'b1;

      runInstr("adi", 4'd4, 6'd0, 0, 0);
      runInstr("lwdWait", 4'd7, 6'd0, 0, 3);
      bcForce = 0;
      runInstr("beqNotTaken", 4'd1, 6'd0, 0, 0);
      bcForce = 1;
      runInstr("beqTaken", 4'd1, 6'd0, 0, 0);
      bcForce = -1;
      runInstr("jal", 4'd10, 6'd0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         rop = 4'($urandom_range(0, 15));
         rfn = 6'($urandom_range(0, 63));
         if (rop == 4'd15) rfn = fnList[$urandom_range(0, 13)];
         runInstr("random", rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Abort a load while it is stalled in the memory stage
      curTag  = "lwdAbort";
      opcode  = 4'd7;
      funcode = 6'd0;
      expQ.delete();
      buildInstr(4'd7, 6'd0, 0, 5);
      applyStimulus(5);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abortImmediate", zero);
      checkCount("abortImmediate", '0);
      @(negedge clk);
      checkOutput("abortHeld", zero);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      expQ.delete();
      modelCount = 0;
      runInstr("afterReset", 4'd15, 6'd2, 0, 0);

      while (modelCount != MOD - 1) begin
         runInstr("preload", 4'd9, 6'd0, 0, 0);
      end
      runInstr("nopWrap", 4'd12, 6'd0, 0, 0);
      checkCount("wrapZero", '0);

      runInstr("wwd", 4'd15, 6'd28, 1, 0);
      runInstr("hlt", 4'd15, 6'd29, 0, 0);
      for (int n = 0; n < 20; n++) begin
         mem_ready = rnd();
         bcond     = rnd();
         opcode    = 4'($urandom_range(0, 15));
         funcode   = 6'($urandom_range(0, 63));
         @(negedge clk);
         checkOutput("haltHold", haltV);
         checkCount("haltFrozen", 10'd2);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WORD_SIZE, default 16, sets datapath word width; only the num_inst output uses it.
REQ-002 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  4  instruction-register bits [15:12].
- funcode  in  6  instruction-register bits [5:0].
- mem_ready  in  1  memory access completes this cycle.
- bcond  in  1  branch-taken flag from the ALU.
- mem_read, mem_write, i_or_d  out  1 each  memory request, direction, address select (0 = PC, 1 = ALU out).
- ir_write, pc_write, pc_write_cond, reg_write  out  1 each  register enables.
- pc_source  out  2  0 PC+1, 1 ALU out, 2 {PC[15:12], target12}, 3 rs.
- reg_dst  out  2  0 rt, 1 rd, 2 register $2.
- mem_to_reg  out  2  0 ALU out, 1 MDR, 2 PC.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  0 rt, 1 sign-extended imm8, 2 zero-extended imm8.
- wwd_en  out  1  output-port write strobe.
- halted  out  1  processor halted.
- num_inst  out  WORD_SIZE  retired-instruction count.

Function
REQ-003 States SHALL be IF, ID, EX, MEM, WB, HALT; one state per clock; every output not listed for a state SHALL be 0.
REQ-004 IF SHALL assert mem_read with i_or_d=0 and hold in IF while mem_ready=0.
REQ-005 IF with mem_ready=1 SHALL pulse ir_write and pc_write (pc_source=0), then go to ID.
REQ-006 ID, JMP (opcode 9): pc_write, pc_source=2, retire, go to IF.
REQ-007 ID, JAL (opcode 10): JMP actions plus reg_write, reg_dst=2, mem_to_reg=2.
REQ-008 ID, JPR (opcode 15, func 25): pc_write, pc_source=3, retire, go to IF.
REQ-009 ID, JRL (opcode 15, func 26): JPR actions plus reg_write, reg_dst=2, mem_to_reg=2.
REQ-010 ID, WWD (opcode 15, func 28): one-cycle wwd_en, retire, go to IF.
REQ-011 ID, HLT (opcode 15, func 29): retire, go to HALT.
REQ-012 ID, undefined opcode or funcode: NOP; retire, go to IF.
REQ-013 ID, any other opcode: go to EX.
REQ-014 EX, branch (opcode 0-3): alu_src_a=1, alu_src_b=0, pc_write_cond=1, pc_source=1; retire; go to IF. The PC SHALL update only when bcond=1 in that cycle.
REQ-015 EX, LWD/SWD (7/8): alu_src_a=1, alu_src_b=1, go to MEM.
REQ-016 EX, ADI (4): alu_src_b=1. ORI (5), LHI (6): alu_src_b=2. R-type ALU func 0-7: alu_src_a=1, alu_src_b=0. All four cases go to WB.
REQ-017 MEM SHALL assert i_or_d=1, with mem_read for LWD or mem_write for SWD, and hold while mem_ready=0.
REQ-018 MEM with mem_ready=1: LWD goes to WB; SWD retires and goes to IF.
REQ-019 WB: reg_write=1; reg_dst=1 for R-type, else 0; mem_to_reg=1 for LWD, else 0; retire; go to IF.
REQ-020 Retire SHALL increment num_inst by 1 on the state-exit edge, wrapping modulo 2^WORD_SIZE (0xFFFF to 0x0000).
REQ-021 HALT SHALL be absorbing, assert halted=1 with all other outputs 0, and freeze num_inst; only reset leaves HALT.
REQ-022 Each instruction SHALL retire exactly once. Worst-case latency with mem_ready tied high: LWD 5 cycles, ALU op 4, branch 3, jump/WWD 2.

Reset
REQ-023 While reset_n=0, state SHALL be IF, num_inst SHALL be 0, and every output including halted SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-instruction SHALL abort it without retiring it.
REQ-025 Fetch SHALL begin on the first rising clk edge after reset_n rises.

Structure
REQ-026 State encodings, opcode/funcode constants and the pc_source/reg_dst/mem_to_reg/alu_src_b encodings SHALL live in the shared macro header.
REQ-027 Decode SHALL be one sub-module, opcode_decode: combinational opcode/funcode to instruction-class flags, instantiated once.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- ADI with mem_ready=1 -> IF, ID, EX, WB; reg_write in cycle 4 only; num_inst 0 to 1.
- LWD with mem_ready low 3 cycles in MEM -> mem_read and i_or_d=1 held 4 cycles; then WB with mem_to_reg=1; one retire.
- BEQ with bcond=0, then BEQ with bcond=1 -> pc_write_cond both times, pc_source=1; num_inst +2; 3 cycles each.
- JAL -> in ID: pc_write, reg_write, reg_dst=2, mem_to_reg=2; back to IF the next cycle.
- WWD then HLT -> one wwd_en pulse; halted=1 and held 20 cycles; num_inst frozen at 2.
- num_inst preloaded to 0xFFFF by running instructions, then one NOP -> 0x0000; reset_n low mid-MEM -> outputs 0 immediately, no retire.
